// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
// Accepts a byte-aligned message as big-endian 32-bit words and emits
// SHA-256 padded 512-bit chunks: message bytes, a 0x80 marker, zero fill and
// the 64-bit message length in bits in the last two words of the final chunk.
// When the marker or the length does not fit, an extra all-padding chunk is
// built after the current chunk has been taken.
module sha256_msg_padder #(
  parameter int CHUNKSIZE = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [2:0]           in_nbytes,
  output logic                 in_ready,
  output logic [CHUNKSIZE-1:0] chunk_data,
  output logic                 chunk_valid,
  output logic                 chunk_last,
  input  logic                 chunk_ready
);

  localparam int NWORDS = CHUNKSIZE / 32;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    PADX = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  wcnt_reg, wcnt_next;
  logic [63:0] len_reg, len_next;
  logic        last_reg, last_next;   // presented chunk is the final one
  logic        pend_reg, pend_next;   // an extra padding chunk must follow
  logic        mark_reg, mark_next;   // extra chunk starts with the 0x80 marker

  logic        accept;
  logic [63:0] len_sum;
  logic [31:0] word_masked;
  logic [4:0]  pad_pos;
  logic        len_fits;

  assign accept   = (state_reg == FILL) && in_valid;
  assign len_sum  = len_reg + {58'd0, in_nbytes, 3'd0};
  // Slot holding the 0x80 marker for a last word: the word itself when it is
  // partial, otherwise the next slot (16 means it spills into an extra chunk).
  assign pad_pos  = {1'b0, wcnt_reg} + ((in_nbytes == 3'd4) ? 5'd1 : 5'd0);
  assign len_fits = (pad_pos <= 5'd13);

  // Byte lanes of the incoming word: keep valid bytes, place the marker in the
  // first unused lane of a last word, clear everything else.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_lane
      assign word_masked[31-8*gi -: 8] =
        (in_nbytes > 3'(gi))                 ? in_data[31-8*gi -: 8] :
        (in_last && (in_nbytes == 3'(gi)))   ? 8'h80 : 8'h00;
    end
  endgenerate

  // One register per chunk word; each slot decides its own next value.
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : gen_word
      logic [31:0] word_reg, word_next;

      // Next word value: data or padding on an accepted word, fixed padding
      // pattern while building the extra chunk, otherwise hold.
      always_comb begin
        word_next = word_reg;
        if (state_reg == PADX) begin
          if (gi == 0)
            word_next = mark_reg ? 32'h8000_0000 : 32'h0000_0000;
          else if (gi == NWORDS - 2)
            word_next = len_reg[63:32];
          else if (gi == NWORDS - 1)
            word_next = len_reg[31:0];
          else
            word_next = '0;
        end else if (accept) begin
          if (wcnt_reg == 4'(gi)) begin
            word_next = word_masked;
          end else if (in_last && (4'(gi) > wcnt_reg)) begin
            if (5'(gi) == pad_pos)
              word_next = 32'h8000_0000;
            else if (len_fits && (gi == NWORDS - 2))
              word_next = len_sum[63:32];
            else if (len_fits && (gi == NWORDS - 1))
              word_next = len_sum[31:0];
            else
              word_next = '0;
          end
        end
      end

      // Word storage, cleared by reset.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          word_reg <= '0;
        else
          word_reg <= word_next;
      end

      assign chunk_data[32*gi +: 32] = word_reg;
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_reg <= FILL;
    else
      state_reg <= state_next;
  end

  // FSM next state: a full or final chunk is held until taken, then either
  // the extra padding chunk is built or collection resumes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL: begin
        if (accept && (in_last || (wcnt_reg == 4'd15)))
          state_next = HOLD;
      end
      HOLD: begin
        if (chunk_ready)
          state_next = pend_reg ? PADX : FILL;
      end
      PADX: state_next = HOLD;
      default: state_next = FILL;
    endcase
  end

  // FSM outputs: handshakes depend only on the state.
  always_comb begin
    in_ready    = (state_reg == FILL);
    chunk_valid = (state_reg == HOLD);
    chunk_last  = (state_reg == HOLD) && last_reg;
  end

  // Control next values: word counter, bit length and chunk flags.
  always_comb begin
    wcnt_next = wcnt_reg;
    len_next  = len_reg;
    last_next = last_reg;
    pend_next = pend_reg;
    mark_next = mark_reg;
    case (state_reg)
      FILL: begin
        if (accept) begin
          len_next = len_sum;
          if (in_last) begin
            wcnt_next = '0;
            last_next = len_fits;
            pend_next = !len_fits;
            mark_next = pad_pos[4];
          end else begin
            wcnt_next = wcnt_reg + 4'd1;
            last_next = 1'b0;
            pend_next = 1'b0;
            mark_next = 1'b0;
          end
        end
      end
      HOLD: begin
        if (chunk_ready) begin
          wcnt_next = '0;
          if (pend_reg)
            pend_next = 1'b0;
          else if (last_reg)
            len_next = '0;
        end
      end
      PADX: begin
        last_next = 1'b1;
        mark_next = 1'b0;
      end
      default: ;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt_reg <= '0;
      len_reg  <= '0;
      last_reg <= 1'b0;
      pend_reg <= 1'b0;
      mark_reg <= 1'b0;
    end else begin
      wcnt_reg <= wcnt_next;
      len_reg  <= len_next;
      last_reg <= last_next;
      pend_reg <= pend_next;
      mark_reg <= mark_next;
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Testbench for sha256_msg_padder: directed vectors plus random messages,
// checked against a byte-level SHA-256 padding model.
`timescale 1ns/1ps
module tb_sha256_msg_padder;

  logic         clk;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         in_ready;
  logic [511:0] chunk_data;
  logic         chunk_valid;
  logic         chunk_last;
  logic         chunk_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0]   msg_q[$];
  logic [31:0]  wd_q[$];
  logic [2:0]   wn_q[$];
  logic         wl_q[$];
  logic [511:0] exp_data_q[$];
  logic         exp_last_q[$];
  logic [511:0] rx_data_q[$];
  logic         rx_last_q[$];

  sha256_msg_padder #(.CHUNKSIZE(512)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_nbytes   (in_nbytes),
    .in_ready    (in_ready),
    .chunk_data  (chunk_data),
    .chunk_valid (chunk_valid),
    .chunk_last  (chunk_last),
    .chunk_ready (chunk_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: standard SHA-256 padding of the byte message, cut into chunks.
  task automatic build_expected();
    logic [7:0]   pad[$];
    longint unsigned bits;
    logic [511:0] ch;
    int nch;
    exp_data_q.delete();
    exp_last_q.delete();
    pad  = msg_q;
    bits = longint'(msg_q.size()) * 8;
    pad.push_back(8'h80);
    while ((pad.size() % 64) != 56) pad.push_back(8'h00);
    for (int i = 7; i >= 0; i--) pad.push_back(8'(bits >> (8 * i)));
    nch = pad.size() / 64;
    for (int c = 0; c < nch; c++) begin
      ch = '0;
      for (int j = 0; j < 16; j++)
        ch[32*j +: 32] = {pad[64*c+4*j], pad[64*c+4*j+1], pad[64*c+4*j+2], pad[64*c+4*j+3]};
      exp_data_q.push_back(ch);
      exp_last_q.push_back(c == nch - 1);
    end
  endtask

  // Split the message into input words; unused lanes carry random garbage.
  task automatic build_words(input bit add_empty);
    int n;
    int k;
    logic [31:0] d;
    wd_q.delete();
    wn_q.delete();
    wl_q.delete();
    n = msg_q.size();
    for (int i = 0; i < n; i += 4) begin
      k = (n - i < 4) ? n - i : 4;
      d = $urandom();
      for (int b = 0; b < k; b++) d[31-8*b -: 8] = msg_q[i+b];
      wd_q.push_back(d);
      wn_q.push_back(3'(k));
      wl_q.push_back(1'b0);
    end
    if (n == 0 || ((n % 4) == 0 && add_empty)) begin
      wd_q.push_back($urandom());
      wn_q.push_back(3'd0);
      wl_q.push_back(1'b1);
    end else begin
      wl_q[wl_q.size()-1] = 1'b1;
    end
  endtask

  // Drive one message and collect/check every chunk it produces.
  task automatic run_msg(input string tag, input int ready_pct, input int gap_pct,
                         input int hold_first, input bit chk_padx, input bit add_empty);
    int wi;
    int nw;
    int cyc;
    int hold_left;
    int since_xfer;
    bit vexp;
    logic [511:0] held;
    build_words(add_empty);
    build_expected();
    rx_data_q.delete();
    rx_last_q.delete();
    nw = wd_q.size();
    wi = 0;
    cyc = 0;
    hold_left = hold_first;
    since_xfer = -1;
    vexp = 1'b0;
    held = '0;
    in_valid = 1'b0;
    chunk_ready = 1'b0;
    @(posedge clk); #1;
    while ((wi < nw || exp_data_q.size() > 0) && cyc < 4000) begin
      if (vexp) begin
        check({tag, ":valid_rise"}, 512'(chunk_valid), 512'(1));
        vexp = 1'b0;
      end
      if (since_xfer >= 0) begin
        since_xfer++;
        if (since_xfer == 1) begin
          check({tag, ":padx_gap"}, 512'(chunk_valid), 512'(0));
        end else begin
          check({tag, ":padx_valid"}, 512'(chunk_valid), 512'(1));
          since_xfer = -1;
        end
      end
      if (wi < nw && $urandom_range(99) >= gap_pct) begin
        in_valid  = 1'b1;
        in_data   = wd_q[wi];
        in_nbytes = wn_q[wi];
        in_last   = wl_q[wi];
      end else begin
        in_valid  = 1'b0;
        in_data   = $urandom();
        in_nbytes = 3'($urandom_range(7));
        in_last   = 1'($urandom_range(1));
      end
      if (hold_left > 0 && chunk_valid && rx_data_q.size() == 0) begin
        chunk_ready = 1'b0;
        if (hold_left == hold_first) held = chunk_data;
        else check({tag, ":hold_stable"}, chunk_data, held);
        check({tag, ":hold_in_ready"}, 512'(in_ready), 512'(0));
        hold_left--;
      end else begin
        chunk_ready = ($urandom_range(99) < ready_pct);
      end
      #1;
      if (chunk_valid && chunk_ready) begin
        check({tag, ":chunk_expected"}, 512'(exp_data_q.size() != 0), 512'(1));
        check({tag, ":xfer_in_ready"}, 512'(in_ready), 512'(0));
        if (exp_data_q.size() != 0) begin
          $display("chunk %s #%0d last=%0b", tag, rx_data_q.size(), chunk_last);
          check({tag, ":data"}, chunk_data, exp_data_q[0]);
          check({tag, ":last"}, 512'(chunk_last), 512'(exp_last_q[0]));
          if (chk_padx && rx_data_q.size() == 0 && !chunk_last) since_xfer = 0;
          rx_data_q.push_back(chunk_data);
          rx_last_q.push_back(chunk_last);
          void'(exp_data_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (wl_q[wi] || (wi % 16) == 15) vexp = 1'b1;
        wi++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chunk_ready = 1'b0;
    check({tag, ":no_timeout"}, 512'(cyc < 4000), 512'(1));
    check({tag, ":idle_in_ready"}, 512'(in_ready), 512'(1));
  endtask

  task automatic fill_msg(input int len);
    msg_q.delete();
    repeat (len) msg_q.push_back(8'($urandom()));
  endtask

  initial begin
    logic [511:0] e;
    reset       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_nbytes   = '0;
    chunk_ready = 1'b0;

    // Reset state
    #12;
    check("rst_chunk_valid", 512'(chunk_valid), 512'(0));
    check("rst_chunk_last", 512'(chunk_last), 512'(0));
    check("rst_chunk_data", chunk_data, 512'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 512'(in_ready), 512'(1));

    // "abc"
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    run_msg("abc", 100, 0, 0, 0, 0);
    e = '0;
    e[31:0] = 32'h6162_6380;
    e[511:480] = 32'h0000_0018;
    check("abc_count", 512'(rx_data_q.size()), 512'(1));
    check("abc_vector", rx_data_q[0], e);
    check("abc_last", 512'(rx_last_q[0]), 512'(1));

    // 55 bytes: marker in the low byte of w[13], length fits
    fill_msg(55);
    run_msg("m55", 100, 0, 0, 0, 0);
    check("m55_count", 512'(rx_data_q.size()), 512'(1));
    check("m55_w13_low", 512'(rx_data_q[0][32*13 +: 8]), 512'(8'h80));
    check("m55_w14", 512'(rx_data_q[0][32*14 +: 32]), 512'(0));
    check("m55_w15", 512'(rx_data_q[0][511:480]), 512'(32'h0000_01B8));

    // 56 bytes with 10 cycles of backpressure on the first chunk
    fill_msg(56);
    run_msg("m56", 100, 0, 10, 1, 0);
    e = '0;
    e[511:480] = 32'h0000_01C0;
    check("m56_count", 512'(rx_data_q.size()), 512'(2));
    check("m56_c0_w14", 512'(rx_data_q[0][32*14 +: 32]), 512'(32'h8000_0000));
    check("m56_c0_w15", 512'(rx_data_q[0][511:480]), 512'(0));
    check("m56_c0_last", 512'(rx_last_q[0]), 512'(0));
    check("m56_c1", rx_data_q[1], e);
    check("m56_c1_last", 512'(rx_last_q[1]), 512'(1));

    // 64 bytes: marker overflows into the extra chunk
    fill_msg(64);
    run_msg("m64", 100, 0, 0, 1, 0);
    e = '0;
    e[31:0] = 32'h8000_0000;
    e[511:480] = 32'h0000_0200;
    check("m64_count", 512'(rx_data_q.size()), 512'(2));
    check("m64_c0_last", 512'(rx_last_q[0]), 512'(0));
    check("m64_c1", rx_data_q[1], e);
    check("m64_c1_last", 512'(rx_last_q[1]), 512'(1));

    // Reset after 5 words, then an empty message
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_data   = $urandom() | 32'h0000_0001;
      in_nbytes = 3'd4;
      in_last   = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_async_data", chunk_data, 512'(0));
    check("midrst_async_valid", 512'(chunk_valid), 512'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 512'(chunk_valid), 512'(0));
    check("midrst_in_ready", 512'(in_ready), 512'(1));
    msg_q.delete();
    run_msg("empty", 60, 30, 0, 0, 0);
    e = '0;
    e[31:0] = 32'h8000_0000;
    check("empty_count", 512'(rx_data_q.size()), 512'(1));
    check("empty_vector", rx_data_q[0], e);
    check("empty_last", 512'(rx_last_q[0]), 512'(1));

    // Random messages, random gaps and backpressure
    for (int m = 0; m < 25; m++) begin
      fill_msg($urandom_range(0, 140));
      run_msg($sformatf("rnd%0d", m), 70, 30, 0, 0, 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
